// File: rtl/syn_fifo_fwft_if.sv
// rtl/syn_fifo_fwft_if.sv - Write/read handshake and status bundle for syn_fifo_fwft
interface syn_fifo_fwft_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  clear;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   // Producer/consumer side: issues requests, observes data and status
   modport master (
      output clear, wr_en, data_in, rd_en,
      input  data_out, valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   // FIFO side
   modport slave (
      input  clear, wr_en, data_in, rd_en,
      output data_out, valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/syn_fifo_fwft.sv
// rtl/syn_fifo_fwft.sv - Single-clock FIFO with standard or first-word-fall-through read
module syn_fifo_fwft #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int FWFT       = 0,
   parameter int AF_TH      = (1 << ADDR_WIDTH) - 2,
   parameter int AE_TH      = 2
) (
   input  logic           clk,
   input  logic           rst,
   syn_fifo_fwft_if.slave bus
);
   localparam int                DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AF_TH_C = (ADDR_WIDTH+1)'(AF_TH);
   localparam logic [ADDR_WIDTH:0] AE_TH_C = (ADDR_WIDTH+1)'(AE_TH);

   // Storage has no reset: contents are meaningless once the pointers are cleared
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_q, valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   logic                  full_w;
   logic                  empty_w;
   logic                  wr_accept;
   logic                  rd_accept;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] head_w;

   // Status comes only from the registered count, never from wr_en/rd_en
   assign full_w  = (count_q == DEPTH_C);
   assign empty_w = (count_q == '0);

   // Head word as seen by the fall-through read port; forced to zero while empty
   assign head_w = empty_w ? '0 : mem_q[rd_ptr_q];

   // Next-state for pointers, count, read register and error pulses
   always_comb begin
      wr_accept   = bus.wr_en && !full_w;
      rd_accept   = bus.rd_en && !empty_w;
      mem_we      = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      valid_d     = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;

      if (bus.clear) begin
         // Flush wins over any concurrent request and raises no error pulse
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         data_out_d = '0;
      end else begin
         mem_we      = wr_accept;
         overflow_d  = bus.wr_en && !wr_accept;
         underflow_d = bus.rd_en && !rd_accept;

         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end

         case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase

         // Standard mode captures the head word on an accepted read
         if (FWFT == 0 && rd_accept) begin
            data_out_d = mem_q[rd_ptr_q];
            valid_d    = 1'b1;
         end
      end
   end

   // Control state register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         valid_q     <= valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Word storage write port
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= bus.data_in;
      end
   end

   assign bus.data_out     = (FWFT != 0) ? head_w   : data_out_q;
   assign bus.valid        = (FWFT != 0) ? !empty_w : valid_q;
   assign bus.full         = full_w;
   assign bus.empty        = empty_w;
   assign bus.almost_full  = (count_q >= AF_TH_C);
   assign bus.almost_empty = (count_q <= AE_TH_C);
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_syn_fifo_fwft.sv
// tb/tb_syn_fifo_fwft.sv - Self-checking bench for syn_fifo_fwft in both read modes
module tb_syn_fifo_fwft;
   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clear = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] data_in = '0;

   always #5 clk = ~clk;

   syn_fifo_fwft_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
   syn_fifo_fwft_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

   assign if0.clear = clear;
   assign if0.wr_en = wr_en;
   assign if0.rd_en = rd_en;
   assign if0.data_in = data_in;
   assign if1.clear = clear;
   assign if1.wr_en = wr_en;
   assign if1.rd_en = rd_en;
   assign if1.data_in = data_in;

   syn_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_TH(AF), .AE_TH(AE))
      dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   syn_fifo_fwft #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_TH(AF), .AE_TH(AE))
      dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   // Reference model: a queue of stored words plus the standard-mode read register
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout0;
   logic          m_valid0;
   logic          m_ovf;
   logic          m_udf;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic          we;
      logic          re;
      logic [DW-1:0] din;
      int            cnt;
      logic          ovf;
      logic          udf;
      logic          vld0;
      logic [DW-1:0] dout0;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("count0", 32'(if0.count), n);
      chk("count1", 32'(if1.count), n);
      chk("empty0", 32'(if0.empty), 32'(n == 0));
      chk("empty1", 32'(if1.empty), 32'(n == 0));
      chk("full0", 32'(if0.full), 32'(n == DEPTH));
      chk("full1", 32'(if1.full), 32'(n == DEPTH));
      chk("afull0", 32'(if0.almost_full), 32'(n >= AF));
      chk("afull1", 32'(if1.almost_full), 32'(n >= AF));
      chk("aempty0", 32'(if0.almost_empty), 32'(n <= AE));
      chk("aempty1", 32'(if1.almost_empty), 32'(n <= AE));
      chk("ovf0", 32'(if0.overflow), 32'(m_ovf));
      chk("ovf1", 32'(if1.overflow), 32'(m_ovf));
      chk("udf0", 32'(if0.underflow), 32'(m_udf));
      chk("udf1", 32'(if1.underflow), 32'(m_udf));
      chk("valid0", 32'(if0.valid), 32'(m_valid0));
      chk("dout0", 32'(if0.data_out), 32'(m_dout0));
      chk("valid1", 32'(if1.valid), 32'(n != 0));
      if (n != 0) chk("dout1", 32'(if1.data_out), 32'(q[0]));
   endtask

   task automatic model_reset();
      q.delete();
      m_dout0  = '0;
      m_valid0 = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
   endtask

   task automatic step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
      int n;
      bit wa, ra;
      clear   = c;
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      @(posedge clk);
      n = q.size();
      if (c) begin
         model_reset();
      end else begin
         wa = w && (n < DEPTH);
         ra = r && (n > 0);
         m_ovf    = w && !wa;
         m_udf    = r && !ra;
         m_valid0 = ra;
         if (ra) m_dout0 = q.pop_front();
         if (wa) q.push_back(d);
      end
      #1;
      check_all();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_count0"}, 32'(if0.count), 0);
      chk({tag, "_count1"}, 32'(if1.count), 0);
      chk({tag, "_empty0"}, 32'(if0.empty), 1);
      chk({tag, "_empty1"}, 32'(if1.empty), 1);
      chk({tag, "_full"}, 32'({if0.full, if1.full}), 0);
      chk({tag, "_aempty"}, 32'({if0.almost_empty, if1.almost_empty}), 3);
      chk({tag, "_afull"}, 32'({if0.almost_full, if1.almost_full}), 0);
      chk({tag, "_dout0"}, 32'(if0.data_out), 0);
      chk({tag, "_dout1"}, 32'(if1.data_out), 0);
      chk({tag, "_valid"}, 32'({if0.valid, if1.valid}), 0);
      chk({tag, "_ovf"}, 32'({if0.overflow, if1.overflow}), 0);
      chk({tag, "_udf"}, 32'({if0.underflow, if1.underflow}), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Fill then drain, with the 9th write and 9th read rejected
      for (int i = 0; i < 9; i++)
         vecs[i] = '{1'b1, 1'b0, 8'(i), (i < 8) ? i + 1 : 8, i == 8, 1'b0, 1'b0, 8'h00};
      for (int j = 0; j < 9; j++)
         vecs[9 + j] = '{1'b0, 1'b1, 8'h00, (j < 8) ? 7 - j : 0, 1'b0, j == 8,
                         j < 8, (j < 8) ? 8'(j) : 8'h07};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("init");
      @(negedge clk);
      rst = 1'b1;

      for (int k = 0; k < 18; k++) begin
         step(1'b0, vecs[k].we, vecs[k].re, vecs[k].din);
         chk($sformatf("vec%0d_cnt", k), 32'(if0.count), vecs[k].cnt);
         chk($sformatf("vec%0d_ovf", k), 32'(if1.overflow), 32'(vecs[k].ovf));
         chk($sformatf("vec%0d_udf", k), 32'(if1.underflow), 32'(vecs[k].udf));
         chk($sformatf("vec%0d_vld0", k), 32'(if0.valid), 32'(vecs[k].vld0));
         chk($sformatf("vec%0d_dout0", k), 32'(if0.data_out), 32'(vecs[k].dout0));
      end

      // Simultaneous read and write at level 4
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h10 + 8'(i));
      step(1'b0, 1'b1, 1'b1, 8'h20);
      chk("rw4_count", 32'(if1.count), 4);
      chk("rw4_dout0", 32'(if0.data_out), 32'h10);
      chk("rw4_head1", 32'(if1.data_out), 32'h11);

      // Simultaneous read and write at full
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h30 + 8'(i));
      chk("pre_full", 32'(if0.full), 1);
      step(1'b0, 1'b1, 1'b1, 8'hEE);
      chk("rwfull_count", 32'(if0.count), 7);
      chk("rwfull_ovf", 32'({if0.overflow, if1.overflow}), 3);

      // Simultaneous read and write at empty
      while (q.size() != 0) step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'h5A);
      chk("rwempty_count", 32'(if1.count), 1);
      chk("rwempty_udf", 32'({if0.underflow, if1.underflow}), 3);
      chk("rwempty_head1", 32'(if1.data_out), 32'h5A);
      step(1'b0, 1'b0, 1'b1, 8'h00);

      // FWFT latency: write into empty, then read in the following cycle
      step(1'b0, 1'b1, 1'b0, 8'h3C);
      chk("lat_fwft_dout", 32'(if1.data_out), 32'h3C);
      chk("lat_fwft_valid", 32'(if1.valid), 1);
      chk("lat_std_valid", 32'(if0.valid), 0);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("lat_std_dout", 32'(if0.data_out), 32'h3C);
      chk("lat_std_valid2", 32'(if0.valid), 1);

      // Wrap-around: 20 back-to-back transfers at level 3
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(100 + i));
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
      chk("wrap_count", 32'(if0.count), 3);

      // Clear at count 5 with concurrent requests
      while (q.size() < 5) step(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
      step(1'b1, 1'b1, 1'b1, 8'h77);
      chk("clr_count", 32'(if0.count), 0);
      chk("clr_dout", 32'({if0.data_out, if1.data_out}), 0);
      chk("clr_flags", 32'({if0.overflow, if0.underflow, if1.overflow, if1.underflow}), 0);
      chk("clr_empty", 32'({if0.empty, if1.empty, if0.almost_empty, if1.almost_empty}), 15);

      // Asynchronous reset mid-stream at count 5
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h40 + 8'(i));
      step(1'b0, 1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h45);
      wr_en = 1'b1;
      data_in = 8'h99;
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_reset_vals("arst");
      wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 1'b1, 1'b0, 8'hA5);
      chk("arst_wr_count", 32'(if0.count), 1);
      chk("arst_head1", 32'(if1.data_out), 32'hA5);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("arst_rd_dout0", 32'(if0.data_out), 32'hA5);

      // Randomized traffic in phases biased towards filling and draining
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 60; i++) begin
            logic c, w, r;
            c = ($urandom_range(0, 63) == 0);
            w = ($urandom_range(0, 9) < ((p % 2 == 0) ? 8 : 3));
            r = ($urandom_range(0, 9) < ((p % 2 == 0) ? 3 : 8));
            step(c, w, r, 8'($urandom_range(0, 255)));
         end
      end

      clear = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
